// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-wide data memory interface.
// Handles byte-to-word addressing, sub-word load extension and read-modify-write for partial stores.
module load_store_unit #(
    parameter int MEM_WORDS  = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;

    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] loaded;
    logic [31:0] merged;

    assign req_err = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                     (req_addr[31:2] >= LIMIT);

    // Lane position comes from the latched address; alignment was validated at accept.
    assign shamt   = {addr_q[1:0], 3'b000};
    assign shifted = mem_read_data >> shamt;

    always_comb begin
        loaded    = mem_read_data;
        lane_mask = '1;
        case (size_q)
            2'b00: begin
                loaded    = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                loaded    = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase
        merged = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                           state_d = RESP;
                    else if (req_write && req_size == 2'b10) state_d = WRITE;
                    else                                   state_d = READ;
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        write_q <= req_write;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        word_q  <= (req_write && !req_err) ? req_wdata : '0;
                    end
                end
                READ:    word_q <= write_q ? merged : loaded;
                default: ;
            endcase
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign MemRead        = (state_q == READ);
    assign MemWrite       = (state_q == WRITE);
    assign mem_addr       = (MemRead || MemWrite) ? {2'b00, addr_q[31:2]} : '0;
    assign mem_write_data = MemWrite ? word_q : '0;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_error      = rsp_valid && err_q;
    assign rsp_rdata      = (rsp_valid && !write_q) ? word_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word behavioural memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [64];
    logic        mem_clr = 1'b1;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(64), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (MemWrite) begin
            mem[mem_addr[5:0]] <= mem_write_data;
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err, input int lat);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat;
        vq.push_back(v);
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    endtask

    task automatic do_req(input int idx, input vec_t v);
        int  lat, nrd, nwr, both;
        bit  seen;
        logic [31:0] rd_seen, err_seen;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        drive(v.wr, v.sz, v.uns, v.addr, v.wdata);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; both = 0; seen = 0;
        rd_seen = '0; err_seen = '0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            if (c > 1) @(negedge clk);
            if (MemRead && MemWrite) both++;
            if (MemRead) begin
                nrd++;
                chk({tag, " rd_addr"}, mem_addr, {2'b00, v.addr[31:2]});
            end
            if (MemWrite) begin
                nwr++;
                chk({tag, " wr_addr"}, mem_addr, {2'b00, v.addr[31:2]});
            end
            if (rsp_valid) begin
                seen = 1; lat = c;
                rd_seen = rsp_rdata; err_seen = {31'b0, rsp_error};
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s timeout: no rsp_valid within 8 cycles", tag);
        end else begin
            chk({tag, " latency"}, 32'(lat), 32'(v.lat));
            chk({tag, " rdata"}, rd_seen, v.rdata);
            chk({tag, " error"}, err_seen, {31'b0, v.err});
            chk({tag, " reads"}, 32'(nrd), (!v.err && (!v.wr || v.sz != 2'b10)) ? 32'd1 : 32'd0);
            chk({tag, " writes"}, 32'(nwr), (!v.err && v.wr) ? 32'd1 : 32'd0);
            chk({tag, " rd_wr_overlap"}, 32'(both), 32'd0);
        end
    endtask

    initial begin
        bit exp_rdy [6];
        bit exp_rsp [6];
        exp_rdy = '{0, 0, 1, 0, 0, 1};
        exp_rsp = '{0, 1, 0, 0, 1, 0};

        //   wr sz     uns addr          wdata          rdata          err lat
        add(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2);
        add(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
        add(0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2);
        add(0, 2'b00, 1, 32'h13, 32'h0,        32'h000000DE, 0, 2);
        add(0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2);
        add(0, 2'b01, 1, 32'h10, 32'h0,        32'h0000BEEF, 0, 2);
        add(0, 2'b00, 0, 32'h10, 32'h0,        32'hFFFFFFEF, 0, 2);
        add(1, 2'b00, 0, 32'h11, 32'h0000005A, 32'h0,        0, 3);
        add(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEAD5AEF, 0, 2);
        add(1, 2'b01, 0, 32'h12, 32'hFFFF1234, 32'h0,        0, 3);
        add(0, 2'b10, 0, 32'h10, 32'h0,        32'h12345AEF, 0, 2);
        add(0, 2'b10, 0, 32'h12, 32'h0,        32'h0,        1, 1);
        add(1, 2'b01, 0, 32'h01, 32'hBEEF,     32'h0,        1, 1);
        add(0, 2'b10, 0, 32'h100, 32'h0,       32'h0,        1, 1);
        add(0, 2'b11, 0, 32'h0,  32'h0,        32'h0,        1, 1);
        add(0, 2'b10, 0, 32'hFC, 32'h0,        32'h0,        0, 2);
        add(1, 2'b10, 0, 32'hFC, 32'hCAFEF00D, 32'h0,        0, 2);
        add(0, 2'b10, 0, 32'hFC, 32'h0,        32'hCAFEF00D, 0, 2);
        add(1, 2'b00, 0, 32'h13, 32'hAAAAAA80, 32'h0,        0, 3);
        add(0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 2);

        // Reset state
        #2;
        chk("rst ready", {31'b0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_error", {31'b0, rsp_error}, 32'd0);
        chk("rst MemRead", {31'b0, MemRead}, 32'd0);
        chk("rst MemWrite", {31'b0, MemWrite}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        rst = 1'b1;

        foreach (vq[i]) do_req(i, vq[i]);

        // Held request: second accept only after the first response
        @(negedge clk);
        chk("hold ready0", {31'b0, req_ready}, 32'd1);
        drive(0, 2'b10, 0, 32'h10, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("hold ready%0d", i + 1), {31'b0, req_ready}, {31'b0, exp_rdy[i]});
            chk($sformatf("hold rsp%0d", i + 1), {31'b0, rsp_valid}, {31'b0, exp_rsp[i]});
            if (exp_rsp[i]) chk($sformatf("hold rdata%0d", i + 1), rsp_rdata, 32'h80345AEF);
        end
        req_valid = 1'b0;

        // Reset during the WRITE cycle of a partial store
        @(negedge clk);
        drive(1, 2'b00, 0, 32'h20, 32'h77);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort MemRead", {31'b0, MemRead}, 32'd1);
        @(negedge clk);
        chk("abort MemWrite pre", {31'b0, MemWrite}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort MemWrite drop", {31'b0, MemWrite}, 32'd0);
        chk("abort ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("abort MemWrite", {31'b0, MemWrite}, 32'd0);
        end
        chk("abort mem untouched", mem[8], 32'd0);
        rst = 1'b1;
        begin
            vec_t v;
            v.wr = 0; v.sz = 2'b00; v.uns = 0; v.addr = 32'h20; v.wdata = 0;
            v.rdata = 32'h0; v.err = 0; v.lat = 2;
            do_req(100, v);
            v.addr = 32'h10; v.sz = 2'b01; v.uns = 1; v.rdata = 32'h00005AEF;
            do_req(101, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
